// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   rx_state_e  : receiver FSM states
//   parity_e    : parity-type encoding of the par_ty input
//   MAX_BITS_*  : legal range of the MAX_BITS parameter
//   clamp_len() : folds a raw data_len request into the legal range
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_e;

    localparam int MAX_BITS_MIN = 5;
    localparam int MAX_BITS_MAX = 9;

    // Requests below the minimum become the minimum, requests above the
    // instance maximum become that maximum.
    function automatic logic [3:0] clamp_len(input logic [3:0] len,
                                             input logic [3:0] max_len);
        if (len < 4'(MAX_BITS_MIN)) begin
            return 4'(MAX_BITS_MIN);
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Line conditioning for the UART receiver: 2-flop synchroniser followed by
// a 3-sample majority voter around the bit centre.
//   clk, rst   : system clock, asynchronous active-low reset
//   os_tick    : oversample strobe
//   cnt        : current oversample position within the bit
//   rx         : raw asynchronous serial line
//   rx_sync    : synchronised line
//   vote       : majority of the samples at OSR/2-1, OSR/2 and the current
//                synced value; meaningful on the tick where cnt = OSR/2+1
module uart_rx_vote #(
    parameter int OSR   = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             os_tick,
    input  logic [CNT_W-1:0] cnt,
    input  logic             rx,
    output logic             rx_sync,
    output logic             vote
);

    localparam logic [CNT_W-1:0] CNT_V0 = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_V1 = CNT_W'(OSR / 2);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic v0_q, v0_d;
    logic v1_q, v1_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        if (os_tick && (cnt == CNT_V0)) begin
            v0_d = sync2_q;
        end
        if (os_tick && (cnt == CNT_V1)) begin
            v1_d = sync2_q;
        end
    end

    // Idle-high reset values so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
        end
    end

    // The third vote is the live synced sample so the decision is available
    // on the same tick that takes it.
    assign rx_sync = sync2_q;
    assign vote    = (v0_q & v1_q) | (v0_q & sync2_q) | (v1_q & sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..MAX_BITS data bits, optional
// even/odd parity, 1 or 2 stop bits) with break detection and a valid/ready
// holding register with overrun detection.
//   clk, rst        : system clock, asynchronous active-low reset
//   os_tick         : oversample strobe, OSR per bit period
//   rx              : asynchronous serial line, idle high
//   data_len, par_en, par_ty, stop2 : frame format, latched at start detect
//   rx_ready        : consumer accepts the held word
//   rx_data         : received word, right-justified, upper bits zero
//   rx_valid        : holding register full
//   parity_error, framing_error : qualify rx_data while rx_valid
//   overrun_error   : pulse, frame dropped because the holder was full
//   break_detect    : pulse, all-zero frame including first stop bit
//   busy            : FSM not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OSR      = 16,
    parameter int MAX_BITS = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                os_tick,
    input  logic                rx,
    input  logic [3:0]          data_len,
    input  logic                par_en,
    input  logic                par_ty,
    input  logic                stop2,
    input  logic                rx_ready,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                parity_error,
    output logic                framing_error,
    output logic                overrun_error,
    output logic                break_detect,
    output logic                busy
);

    localparam int CNT_W   = $clog2(OSR);
    localparam int LEN_MAX = (MAX_BITS > MAX_BITS_MAX) ? MAX_BITS_MAX : MAX_BITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(OSR / 2 + 1);

    rx_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic [3:0]          len_q, len_d;
    logic                cfg_par_en_q, cfg_par_en_d;
    logic                cfg_par_ty_q, cfg_par_ty_d;
    logic                cfg_stop2_q, cfg_stop2_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                par_bit_q, par_bit_d;
    logic                stop_idx_q, stop_idx_d;
    logic                first_stop_q, first_stop_d;

    logic [MAX_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_out_q, perr_out_d;
    logic                ferr_out_q, ferr_out_d;
    logic                ovr_q, ovr_d;
    logic                brk_q, brk_d;

    logic rx_sync;
    logic vote;
    logic at_last;
    logic decide;
    logic exp_par;
    logic first_zero;
    logic frame_done;
    logic frame_brk;
    logic frame_ferr;
    logic load;
    logic [MAX_BITS-1:0] bit_sel;

    uart_rx_vote #(
        .OSR   (OSR),
        .CNT_W (CNT_W)
    ) u_vote (
        .clk     (clk),
        .rst     (rst),
        .os_tick (os_tick),
        .cnt     (cnt_q),
        .rx      (rx),
        .rx_sync (rx_sync),
        .vote    (vote)
    );

    // One-hot write strobe for the data bit currently being received.
    for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_bit_sel
        assign bit_sel[gi] = (idx_q == 4'(gi));
    end

    assign at_last    = (cnt_q == CNT_LAST);
    assign decide     = (cnt_q == CNT_DEC);
    // Bits above len are still zero, so reducing the full register is safe.
    assign exp_par    = (^shift_q) ^ (cfg_par_ty_q == PAR_ODD);
    assign first_zero = stop_idx_q ? ~first_stop_q : ~vote;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        len_d        = len_q;
        cfg_par_en_d = cfg_par_en_q;
        cfg_par_ty_d = cfg_par_ty_q;
        cfg_stop2_d  = cfg_stop2_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        par_bit_d    = par_bit_q;
        stop_idx_d   = stop_idx_q;
        first_stop_d = first_stop_q;
        frame_done   = 1'b0;
        frame_brk    = 1'b0;
        frame_ferr   = ferr_q;

        if (os_tick) begin
            if (state_q != IDLE) begin
                cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (!rx_sync) begin
                        state_d      = START;
                        cnt_d        = '0;
                        idx_d        = '0;
                        shift_d      = '0;
                        len_d        = clamp_len(data_len, 4'(LEN_MAX));
                        cfg_par_en_d = par_en;
                        cfg_par_ty_d = par_ty;
                        cfg_stop2_d  = stop2;
                        perr_d       = 1'b0;
                        ferr_d       = 1'b0;
                        par_bit_d    = 1'b0;
                        stop_idx_d   = 1'b0;
                        first_stop_d = 1'b1;
                    end
                end
                START: begin
                    if (decide && vote) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (at_last) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_d = shift_q | (bit_sel & {MAX_BITS{vote}});
                    end
                    if (at_last) begin
                        if (idx_q == len_q - 4'd1) begin
                            state_d    = cfg_par_en_q ? PARITY : STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        par_bit_d = vote;
                        if (vote != exp_par) begin
                            perr_d = 1'b1;
                        end
                    end
                    if (at_last) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                    end
                end
                STOP: begin
                    if (decide) begin
                        frame_ferr = ferr_q | ~vote;
                        ferr_d     = frame_ferr;
                        if (cfg_stop2_q && !stop_idx_q) begin
                            first_stop_d = vote;
                        end else begin
                            // Finish mid-bit so the next start edge is not missed.
                            frame_done = 1'b1;
                            frame_brk  = (shift_q == '0) && (!cfg_par_en_q || !par_bit_q)
                                         && first_zero;
                            state_d    = frame_brk ? BRK_WAIT : IDLE;
                            cnt_d      = '0;
                        end
                    end
                    if (at_last && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end
                end
                BRK_WAIT: begin
                    if (rx_sync) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Holding register: a completed frame either loads (holder empty or
    // being drained this cycle) or is dropped as an overrun.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        load       = frame_done && !frame_brk && (!valid_q || rx_ready);
        ovr_d      = frame_done && !frame_brk && valid_q && !rx_ready;
        brk_d      = frame_done && frame_brk;
        if (load) begin
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = frame_ferr;
            valid_d    = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            len_q        <= 4'(MAX_BITS_MIN);
            cfg_par_en_q <= 1'b0;
            cfg_par_ty_q <= 1'b0;
            cfg_stop2_q  <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            par_bit_q    <= 1'b0;
            stop_idx_q   <= 1'b0;
            first_stop_q <= 1'b1;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_out_q   <= 1'b0;
            ferr_out_q   <= 1'b0;
            ovr_q        <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            len_q        <= len_d;
            cfg_par_en_q <= cfg_par_en_d;
            cfg_par_ty_q <= cfg_par_ty_d;
            cfg_stop2_q  <= cfg_stop2_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            par_bit_q    <= par_bit_d;
            stop_idx_q   <= stop_idx_d;
            first_stop_q <= first_stop_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            perr_out_q   <= perr_out_d;
            ferr_out_q   <= ferr_out_d;
            ovr_q        <= ovr_d;
            brk_q        <= brk_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign parity_error  = perr_out_q;
    assign framing_error = ferr_out_q;
    assign overrun_error = ovr_q;
    assign break_detect  = brk_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int OSR      = 16;
    localparam int MAX_BITS = 9;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                os_tick = 1'b0;
    logic                rx = 1'b1;
    logic [3:0]          data_len = 4'd8;
    logic                par_en = 1'b0;
    logic                par_ty = 1'b0;
    logic                stop2 = 1'b0;
    logic                rx_ready = 1'b1;
    logic [MAX_BITS-1:0] rx_data;
    logic                rx_valid;
    logic                parity_error;
    logic                framing_error;
    logic                overrun_error;
    logic                break_detect;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } word_t;

    word_t got_q[$];
    int    ovr_cnt = 0;
    int    brk_cnt = 0;
    int    tick_div = 0;

    uart_rx_cfg #(
        .OSR      (OSR),
        .MAX_BITS (MAX_BITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .os_tick       (os_tick),
        .rx            (rx),
        .data_len      (data_len),
        .par_en        (par_en),
        .par_ty        (par_ty),
        .stop2         (stop2),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .break_detect  (break_detect),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Oversample strobe: one clk in every four, changed away from posedge.
    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        os_tick  = (tick_div == 0);
    end

    // Collect handshakes and pulses at the inactive edge.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid && rx_ready) begin
                got_q.push_back('{data: rx_data, perr: parity_error, ferr: framing_error});
            end
            if (overrun_error) ovr_cnt++;
            if (break_detect)  brk_cnt++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!os_tick) @(posedge clk);
        end
    endtask

    // Reference model + line driver. The expected outcome is computed from
    // the frame-format rules alone, then the frame is sent bit by bit.
    task automatic send_frame(input logic [8:0] data, input logic [3:0] len_raw,
                              input bit pe, input bit pty, input bit two,
                              input bit pflip, input bit s1, input bit s2,
                              input bit scramble, output word_t w, output bit brk);
        int   len_eff;
        int   ones;
        int   masked;
        bit   pbit;
        bit   bits_q[$];
        len_eff = (len_raw < 5) ? 5 : ((len_raw > MAX_BITS) ? MAX_BITS : int'(len_raw));
        masked  = int'(data) % (1 << len_eff);
        ones    = $countones(masked);
        pbit    = bit'(((ones + int'(pty)) % 2) != 0) ^ pflip;
        w.data  = 9'(masked);
        w.perr  = pe && pflip;
        w.ferr  = !s1 || (two && !s2);
        brk     = (masked == 0) && (!pe || !pbit) && !s1;

        bits_q.push_back(1'b0);
        for (int i = 0; i < len_eff; i++) bits_q.push_back(bit'((masked >> i) & 1));
        if (pe) bits_q.push_back(pbit);
        bits_q.push_back(s1);
        if (two) bits_q.push_back(s2);

        data_len = len_raw;
        par_en   = pe;
        par_ty   = pty;
        stop2    = two;
        wait_ticks(1);
        #1;
        for (int i = 0; i < bits_q.size(); i++) begin
            rx = bits_q[i];
            wait_ticks(OSR);
            #1;
            if (i == 0 && scramble) begin
                data_len = 4'($urandom_range(0, 15));
                par_en   = 1'($urandom);
                par_ty   = 1'($urandom);
                stop2    = 1'($urandom);
            end
        end
        rx = 1'b1;
        wait_ticks(3 * OSR);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rx_data, rx_valid, parity_error, framing_error, overrun_error, break_detect, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got data=%h valid=%b pe=%b fe=%b ov=%b brk=%b busy=%b, required all 0",
                     rx_data, rx_valid, parity_error, framing_error, overrun_error, break_detect, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(4);
        #1;
    endtask

    task automatic test_8n1;
        word_t w;
        bit    brk;
        rx_ready = 1'b1;
        got_q.delete();
        send_frame(9'h0A5, 4'd8, 0, 0, 0, 0, 1, 1, 0, w, brk);
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++;
            $display("FAIL 8n1_count: got %0d words, required 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].data !== 9'h0A5 || got_q[0].data !== w.data) begin
                n_fail++;
                $display("FAIL 8n1_data: got %h, required %h", got_q[0].data, w.data);
            end
            n_checks++;
            if ({got_q[0].perr, got_q[0].ferr} !== 2'b00) begin
                n_fail++;
                $display("FAIL 8n1_flags: got pe=%b fe=%b, required 0 0", got_q[0].perr, got_q[0].ferr);
            end
        end
        $display("8n1 frame 0x0A5 done, words=%0d", got_q.size());
    endtask

    task automatic test_parity_7e2;
        word_t w;
        bit    brk;
        for (int k = 0; k < 2; k++) begin
            got_q.delete();
            send_frame(9'h055, 4'd7, 1, 0, 1, (k == 0), 1, 1, 0, w, brk);
            n_checks++;
            if (got_q.size() !== 1) begin
                n_fail++;
                $display("FAIL 7e2_count[%0d]: got %0d words, required 1", k, got_q.size());
            end else begin
                n_checks++;
                if (got_q[0].data !== w.data) begin
                    n_fail++;
                    $display("FAIL 7e2_data[%0d]: got %h, required %h", k, got_q[0].data, w.data);
                end
                n_checks++;
                if (got_q[0].perr !== w.perr || got_q[0].ferr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL 7e2_flags[%0d]: got pe=%b fe=%b, required pe=%b fe=0",
                             k, got_q[0].perr, got_q[0].ferr, w.perr);
                end
            end
            $display("7e2 frame 0x055 wrong_parity=%0d done", (k == 0));
        end
    endtask

    task automatic test_framing_9o1;
        word_t w;
        bit    brk;
        got_q.delete();
        send_frame(9'h1FF, 4'd9, 1, 1, 0, 0, 0, 1, 0, w, brk);
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++;
            $display("FAIL 9o1_count: got %0d words, required 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].data !== 9'h1FF) begin
                n_fail++;
                $display("FAIL 9o1_data: got %h, required 1ff", got_q[0].data);
            end
            n_checks++;
            if (got_q[0].ferr !== 1'b1 || got_q[0].perr !== 1'b0) begin
                n_fail++;
                $display("FAIL 9o1_flags: got pe=%b fe=%b, required pe=0 fe=1", got_q[0].perr, got_q[0].ferr);
            end
        end
        $display("9o1 frame 0x1FF bad stop done");
    endtask

    task automatic test_glitch;
        got_q.delete();
        wait_ticks(1);
        #1;
        rx = 1'b0;
        wait_ticks(2);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_start: got busy=%b, required 1", busy);
        end
        rx = 1'b1;
        wait_ticks(OSR);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_end: got busy=%b, required 0", busy);
        end
        wait_ticks(2 * OSR);
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_words: got %0d words, required 0", got_q.size());
        end
        $display("glitch 2 ticks rejected check done");
    endtask

    task automatic test_break;
        int    brk0;
        word_t w;
        bit    brk;
        got_q.delete();
        data_len = 4'd8;
        par_en   = 1'b0;
        stop2    = 1'b0;
        brk0     = brk_cnt;
        wait_ticks(1);
        #1;
        rx = 1'b0;
        wait_ticks(20 * OSR);
        #1;
        n_checks++;
        if (brk_cnt - brk0 !== 1) begin
            n_fail++;
            $display("FAIL break_pulses: got %0d, required 1", brk_cnt - brk0);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL break_hold: got busy=%b, required 1 while line low", busy);
        end
        rx = 1'b1;
        wait_ticks(2 * OSR);
        #1;
        n_checks++;
        if (busy !== 1'b0 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL break_exit: got busy=%b words=%0d, required busy=0 words=0", busy, got_q.size());
        end
        send_frame(9'h03C, 4'd8, 0, 0, 0, 0, 1, 1, 0, w, brk);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0].data !== 9'h03C) begin
            n_fail++;
            $display("FAIL break_after_frame: got words=%0d data=%h, required 1 word 03c",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].data : 9'h000);
        end
        $display("break 20 bit times then 0x03C done");
    endtask

    task automatic test_overrun;
        word_t w;
        bit    brk;
        int    ovr0;
        rx_ready = 1'b0;
        ovr0     = ovr_cnt;
        send_frame(9'h011, 4'd8, 0, 0, 0, 0, 1, 1, 0, w, brk);
        send_frame(9'h022, 4'd8, 0, 0, 0, 0, 1, 1, 0, w, brk);
        n_checks++;
        if (ovr_cnt - ovr0 !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulses: got %0d, required 1", ovr_cnt - ovr0);
        end
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h011) begin
            n_fail++;
            $display("FAIL overrun_hold: got valid=%b data=%h, required valid=1 data=011", rx_valid, rx_data);
        end
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got valid=%b, required 0", rx_valid);
        end
        $display("overrun 0x011/0x022 done");
    endtask

    task automatic test_reset_midframe;
        word_t w;
        bit    brk;
        rx_ready = 1'b0;
        send_frame(9'h033, 4'd8, 0, 0, 0, 0, 1, 1, 0, w, brk);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 9'h033) begin
            n_fail++;
            $display("FAIL midreset_pre: got valid=%b data=%h, required 1 033", rx_valid, rx_data);
        end
        wait_ticks(1);
        #1;
        rx = 1'b0;
        wait_ticks(3 * OSR);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rx_data, rx_valid, parity_error, framing_error, overrun_error, break_detect, busy} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got data=%h valid=%b busy=%b, required all 0", rx_data, rx_valid, busy);
        end
        rx = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(4);
        #1;
        $display("reset mid-frame done");
    endtask

    task automatic test_random;
        word_t w;
        bit    brk;
        int    brk0;
        rx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [8:0] d;
            logic [3:0] l;
            bit pe, pty, two, pflip, s1, s2;
            d     = 9'($urandom);
            l     = 4'($urandom_range(0, 15));
            pe    = 1'($urandom);
            pty   = 1'($urandom);
            two   = 1'($urandom);
            pflip = ($urandom_range(0, 5) == 0);
            s1    = ($urandom_range(0, 5) != 0);
            s2    = ($urandom_range(0, 5) != 0);
            got_q.delete();
            brk0 = brk_cnt;
            send_frame(d, l, pe, pty, two, pflip, s1, s2, 1, w, brk);
            if (brk) begin
                n_checks++;
                if (brk_cnt - brk0 !== 1 || got_q.size() !== 0) begin
                    n_fail++;
                    $display("FAIL rand_break[%0d]: got pulses=%0d words=%0d, required 1 0",
                             k, brk_cnt - brk0, got_q.size());
                end
            end else begin
                n_checks++;
                if (got_q.size() !== 1) begin
                    n_fail++;
                    $display("FAIL rand_count[%0d]: got %0d words, required 1", k, got_q.size());
                end else begin
                    n_checks++;
                    if (got_q[0].data !== w.data || got_q[0].perr !== w.perr || got_q[0].ferr !== w.ferr) begin
                        n_fail++;
                        $display("FAIL rand_word[%0d]: got %h pe=%b fe=%b, required %h pe=%b fe=%b",
                                 k, got_q[0].data, got_q[0].perr, got_q[0].ferr, w.data, w.perr, w.ferr);
                    end
                end
            end
            $display("rand frame %0d: data=%h len=%0d pe=%0d pty=%0d two=%0d brk=%0d",
                     k, w.data, l, pe, pty, two, brk);
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_8n1;
        test_parity_7e2;
        test_framing_9o1;
        test_glitch;
        test_break;
        test_overrun;
        test_reset_midframe;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, configurable UART receiver. Oversampled serial input with a 2-flop synchroniser and 3-sample majority vote. Runtime-selectable data length, parity, and 1/2 stop bits. Break detection, plus a valid/ready output holding register with overrun detection. It sits between the shared baud/oversample tick generator and the byte-stream consumer.

## Interface
Parameters:
- OSR, 16, oversample ticks per bit; even, ≥8.
- MAX_BITS, 9, maximum data bits; width of rx_data; range 5..9.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- os_tick  in  1  one-clk-wide oversample strobe, OSR per bit period.
- rx  in  1  asynchronous serial line; idle high.
- data_len  in  4  data bits per frame; values <5 are treated as 5 and values >MAX_BITS as MAX_BITS.
- par_en  in  1  parity bit present.
- par_ty  in  1  1 = odd, 0 = even.
- stop2  in  1  two stop bits.
- rx_ready  in  1  consumer accepts the held word.
- rx_data  out  MAX_BITS  received word, LSB-first on the line, right-justified, upper bits zero.
- rx_valid  out  1  holding register full.
- parity_error  out  1  qualifies rx_data; valid while rx_valid.
- framing_error  out  1  qualifies rx_data; valid while rx_valid.
- overrun_error  out  1  one-clk pulse: a frame completed while the holding register was full.
- break_detect  out  1  one-clk pulse on break.
- busy  out  1  state ≠ IDLE.

## Operation
- rx passes through 2 flops (reset value 1) before any use. All FSM and counter activity advances only on os_tick.
- cnt counts 0..OSR-1 within each bit. Votes are taken at cnt = OSR/2-1, OSR/2, OSR/2+1. The decision is the majority of the 3 votes, taken at cnt = OSR/2+1.
- data_len, par_en, par_ty and stop2 are latched at start detection. Changes mid-frame are ignored.
- States:
  - IDLE: synced rx = 0 → START with cnt = 0.
  - START: decision = 1 → IDLE (false start). At cnt = OSR-1 → DATA with bit index 0.
  - DATA: the decision is shifted into bit[idx]. After bit len-1, at cnt = OSR-1 → PARITY if par_en, else STOP.
  - PARITY: the expected bit is the XOR of the len data bits, XOR par_ty (so the total 1-count is even for even parity, odd for odd). Mismatch sets perr_int.
  - STOP: on the first stop decision, 0 sets ferr_int. If stop2, continue to a second stop bit and check it the same way. The frame completes at the decision of the last stop bit (mid-bit), and the FSM returns to IDLE on that same tick so a new start edge can be caught early.
  - BRK_WAIT: entered at frame completion when all data bits, the parity bit (if present) and the first stop bit are 0. break_detect pulses and no word is delivered. Exit to IDLE when synced rx = 1.
- Completion with the holding register empty, or with rx_valid && rx_ready on the same clk: load rx_data, parity_error and framing_error, and set rx_valid.
- Completion with rx_valid && !rx_ready: the new frame is dropped, overrun_error pulses, and the old word is kept.
- rx_valid clears on the clk edge where rx_valid && rx_ready, unless a load occurs on the same edge.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, all error flags 0, break_detect = 0, busy = 0, state = IDLE, counters 0.
- Input latency: 2 clk synchroniser plus the os_tick sampling granularity.
- Output latency: rx_valid rises on the clk edge that processes the os_tick carrying the final stop decision.
- Handshake: rx_data and the flags are stable while rx_valid && !rx_ready.
- Reset asserted mid-frame: immediate return to the reset values; the partial frame is discarded.
- A glitch shorter than 2 of the 3 votes in START is rejected as a false start.

## Structure
- Shared package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - parity-type constants: PAR_EVEN = 0, PAR_ODD = 1.
  - MAX_BITS bounds constants.
- One sub-module, uart_rx_vote, contains the 2-flop synchroniser and the 3-sample majority voter. Its outputs are the synced line and the vote result.
- The FSM, shift register and holding register live in uart_rx_cfg.

## Test plan
- 8N1, OSR = 16, byte 0xA5, rx_ready held 1 → rx_valid pulses with rx_data = 0x0A5, no errors.
- 7E2, byte 0x55, wrong parity bit → rx_data = 0x055, parity_error = 1; a second frame sent with correct parity → parity_error = 0.
- 9O1, data 0x1FF, stop bit forced 0 → rx_data = 0x1FF, framing_error = 1.
- 2-tick low glitch on idle rx → no rx_valid and busy returns to 0 within OSR ticks.
- rx held low for 20 bit times (8N1) → single break_detect pulse, no rx_valid. The FSM stays in BRK_WAIT until rx goes high, then frame 0x3C is received correctly.
- rx_ready = 0, frames 0x11 then 0x22 → overrun_error pulses at the second completion and rx_data stays 0x011. Then rx_ready = 1 → rx_valid drops. Reset asserted mid-frame → all outputs 0.
